fir16_out_formatter: RTL
========================

# fir16_out_formatter

Output-side companion to the 16-tap FIR top. It takes the raw signed 36-bit accumulator result every clock and discards results until the tap pipeline has filled. It then rounds and saturates each result back to signed Q1.15 16-bit and buffers it in a small FIFO. Downstream logic reads samples through a valid/ready handshake, and FIFO overflow is reported through sticky status.

## Interface
- DEPTH, 4: FIFO depth in words. Must be a power of two, at least 2.
- WARMUP, 18: leading input results discarded after reset. This covers 16 taps plus 2 MAC pipeline stages.
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- y_in  in  36  signed FIR accumulator result in Q6.30. Valid every clock.
- out_data  out  16  signed Q1.15 sample at the FIFO head.
- out_valid  out  1  FIFO non-empty.
- out_ready  in  1  downstream accept.
- fill_level  out  $clog2(DEPTH)+1  current FIFO occupancy.
- sat_pulse  out  1  one-cycle pulse: the word written this cycle was clipped.
- overflow  out  1  sticky: a result was dropped because the FIFO was full.
- ovf_clear  in  1  synchronous clear of `overflow`.

## Operation
- Warm-up counter:
  - Reset value 0. Increments every clock while below WARMUP.
  - While count < WARMUP, y_in is discarded: no write, no overflow, no sat_pulse.
  - Once the count reaches WARMUP, every clock is a write attempt.
- Rounding, with r = y_in + 2^14 computed at 37 bits:
  - Round half up. Form q = r >>> 15 as an arithmetic shift, giving a 22-bit signed result.
- Saturation (with FIR16_OUT_SAT_EN):
  - q > 32767 gives 0x7FFF.
  - q < -32768 gives 0x8000.
  - Either clip raises sat_pulse in the write cycle.
- FIFO:
  - Circular buffer with read and write pointers one bit wider than the address.
  - Full when the addresses are equal and the MSBs differ. Empty when the pointers are equal.
- Write attempt while full, with no read in the same cycle:
  - The word is dropped and overflow is set.
  - The FIFO contents are unchanged.
- Write attempt while full, with a read in the same cycle (out_valid & out_ready):
  - Both happen and no drop occurs.
  - fill_level stays at DEPTH.
- Read only: fill_level decrements. Write only: fill_level increments.
- Read and write together when not full: fill_level is unchanged.
- out_data shows the head word. It is undefined-free and holds 0 when the FIFO is empty.
- ovf_clear has priority over a same-cycle set. The new drop is lost, and the clear wins.
- Reset deassertion restarts warm-up from 0.
- Reset asserted mid-stream:
  - The FIFO is emptied immediately.
  - out_valid drops asynchronously and all flags clear.

## Timing
- Reset values:
  - out_data=0, out_valid=0, fill_level=0, sat_pulse=0, overflow=0.
  - Warm-up count=0, both pointers=0.
- Latency: y_in sampled at edge k appears on out_data with out_valid=1 after edge k, when the FIFO was empty at edge k. That is 1 clock.
- sat_pulse is registered and high during the cycle after the clipping write edge.
- overflow rises on the clock after the dropping edge.
- A handshake completes on any edge where out_valid & out_ready are both high. out_ready while empty has no effect.
- out_valid never depends combinationally on out_ready.
- First possible write is at edge index WARMUP, counting from 0 at the first edge after reset release.

## Configuration
- FIR16_OUT_SAT_EN defined:
  - Saturating conversion as above. sat_pulse is functional.
- FIR16_OUT_SAT_EN undefined:
  - out word = q[15:0]. Out-of-range values wrap two's-complement.
  - sat_pulse is tied to 0.
  - Rounding and all other behaviour are identical.

## Test plan
- Warm-up:
  - Stimulus: release reset, drive y_in=0x0_4000_0000 constantly (1.0 in Q6.30 is 2^30), out_ready=1.
  - Required: no out_valid for the first 18 edges. First output at edge 18 reads 0x7FFF with sat_pulse=1 under SAT_EN, or 0x8000 without.
- Rounding:
  - Stimulus: y_in=0x0_0000_4000.
  - Required: output is 0x0001 (half rounds up).
  - Stimulus: y_in=-0x0_0000_4001.
  - Required: output is 0xFFFF.
- Negative saturation:
  - Stimulus: y_in=-(2^31).
  - Required: output is 0x8000 with sat_pulse=1 (SAT_EN). Without SAT_EN the output is 0x0000 (wrap).
- Overflow:
  - Stimulus: out_ready=0 after warm-up.
  - Required: fill_level reaches 4 after 4 writes. The 5th edge drops and overflow=1. Draining then returns the first 4 words in order.
  - Stimulus: ovf_clear=1.
  - Required: overflow returns to 0.
- Full with simultaneous read:
  - Stimulus: FIFO full, out_ready=1 continuously.
  - Required: fill_level stays at 4, no overflow, output stream is in order with no gaps.
- Reset mid-stream:
  - Stimulus: assert reset with fill_level=3, then release.
  - Required: out_valid=0 immediately. After release, 18 further discard cycles occur before the next output.

Source files
------------

// File: rtl/fir16_out_formatter_if.sv
// Output sample stream of fir16_out_formatter: Q1.15 head word with a valid/ready handshake.
interface fir16_out_formatter_if;
    logic signed [15:0] out_data;
    logic               out_valid;
    logic               out_ready;

    modport master (output out_data, output out_valid, input  out_ready);
    modport slave  (input  out_data, input  out_valid, output out_ready);
endinterface

// File: rtl/fir16_out_formatter.sv
// Rounds/saturates the 36-bit Q6.30 FIR accumulator to Q1.15 after warm-up and buffers it in a FIFO.
// Define FIR16_OUT_SAT_EN for saturating conversion; otherwise out-of-range values wrap.
module fir16_out_formatter #(
    parameter int DEPTH  = 4,
    parameter int WARMUP = 18
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic signed [35:0]        y_in,
    fir16_out_formatter_if.master     out_if,
    output logic [$clog2(DEPTH):0]    fill_level,
    output logic                      sat_pulse,
    output logic                      overflow,
    input  logic                      ovf_clear
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(WARMUP + 1);

    // Round half up: add 2^14 at 37 bits, then arithmetic shift right by 15.
    function automatic logic signed [21:0] round_q15(input logic signed [35:0] y);
        logic signed [36:0] r;
        r = {y[35], y} + 37'sd16384;
        return r[36:15];
    endfunction

    // Returns {clipped, word}.
    function automatic logic [16:0] sat_q15(input logic signed [21:0] q);
`ifdef FIR16_OUT_SAT_EN
        if (q > 22'sd32767)
            return {1'b1, 16'h7FFF};
        else if (q < -22'sd32768)
            return {1'b1, 16'h8000};
        else
            return {1'b0, q[15:0]};
`else
        return {1'b0, q[15:0]};
`endif
    endfunction

    logic [CW-1:0]      warm_cnt_q, warm_cnt_d;
    logic [AW:0]        wr_ptr_q, wr_ptr_d;
    logic [AW:0]        rd_ptr_q, rd_ptr_d;
    logic               sat_pulse_q, sat_pulse_d;
    logic               overflow_q, overflow_d;
    logic signed [15:0] mem_q [DEPTH];

    logic               warm_done, empty, full, rd_fire, wr_en, drop, clip;
    logic signed [15:0] word;
    logic [16:0]        conv;

    always_comb begin
        warm_done   = (warm_cnt_q == CW'(WARMUP));
        empty       = (wr_ptr_q == rd_ptr_q);
        full        = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
        rd_fire     = !empty && out_if.out_ready;
        // A full FIFO still accepts a write when the head leaves on the same edge.
        wr_en       = warm_done && (!full || rd_fire);
        drop        = warm_done && full && !rd_fire;
        conv        = sat_q15(round_q15(y_in));
        clip        = conv[16];
        word        = conv[15:0];

        warm_cnt_d  = warm_done ? warm_cnt_q : warm_cnt_q + 1'b1;
        wr_ptr_d    = wr_en   ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d    = rd_fire ? rd_ptr_q + 1'b1 : rd_ptr_q;
        sat_pulse_d = wr_en && clip;
        overflow_d  = overflow_q;
        if (ovf_clear)
            overflow_d = 1'b0;
        else if (drop)
            overflow_d = 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            warm_cnt_q  <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            sat_pulse_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            warm_cnt_q  <= warm_cnt_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            sat_pulse_q <= sat_pulse_d;
            overflow_q  <= overflow_d;
        end
    end

    // Storage carries no reset; emptiness is tracked by the pointers alone.
    always_ff @(posedge clk) begin
        if (wr_en)
            mem_q[wr_ptr_q[AW-1:0]] <= word;
    end

    assign out_if.out_valid = !empty;
    assign out_if.out_data  = empty ? 16'sd0 : mem_q[rd_ptr_q[AW-1:0]];
    assign fill_level       = wr_ptr_q - rd_ptr_q;
    assign sat_pulse        = sat_pulse_q;
    assign overflow         = overflow_q;
endmodule
